reg_dump_unit: RTL and testbench

REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

---
 rtl/reg_dump_unit.sv | 106 ++++++++++
 tb/tb_reg_dump_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_unit.sv
// Register bank dump sequencer: reads each register over the debug port and
// streams it to a UART transmitter one byte at a time, most-significant byte first.
module reg_dump_unit #(
  parameter int DATA_SIZE  = 32,
  parameter int ADDR_SIZE  = 5,
  parameter int BANK_DEPTH = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [DATA_SIZE-1:0] i_reg_data,
  input  logic                 i_tx_done,
  output logic                 o_read_enable,
  output logic [ADDR_SIZE-1:0] o_read_addr,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int NBYTES = DATA_SIZE / 8;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(BANK_DEPTH - 1);
  localparam logic [BW-1:0]        LAST_BYTE = BW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_SEND, S_WAIT_TX, S_NEXT, S_FINISH
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [BW-1:0]          byte_q, byte_d;
  logic [DATA_SIZE-1:0]   word_q, word_d;
  logic [DATA_SIZE-1:0]   word_sh;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      byte_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    byte_d  = byte_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d  = '0;
          byte_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ:  state_d = S_LATCH;
      S_LATCH: begin
        word_d  = i_reg_data;
        state_d = S_SEND;
      end
      S_SEND:  state_d = S_WAIT_TX;
      S_WAIT_TX: begin
        if (i_tx_done) begin
          if (byte_q == LAST_BYTE) begin
            state_d = S_NEXT;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = S_SEND;
          end
        end
      end
      S_NEXT: begin
        byte_d = '0;
        if (addr_q == LAST_ADDR) begin
          state_d = S_FINISH;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_READ;
        end
      end
      S_FINISH: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte counter only moves on an accepted tx_done, so this mux stays stable
  // for the whole SEND/WAIT_TX window without a separate output register.
  assign word_sh = word_q << {byte_q, 3'b000};

  assign o_tx_data     = word_sh[DATA_SIZE-1 -: 8];
  assign o_read_enable = (state_q == S_READ);
  assign o_read_addr   = addr_q;
  assign o_tx_start    = (state_q == S_SEND);
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_FINISH);

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: default 32-bit/32-deep instance plus a
// 16-bit/4-deep instance, each with a registered bank model and a tx_done responder.
module tb_reg_dump_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start_a, tx_done_a, rd_en_a, txs_a, busy_a, done_a;
  logic [31:0] rdata_a;
  logic [4:0]  addr_a;
  logic [7:0]  txd_a;

  logic        start_b, tx_done_b, rd_en_b, txs_b, busy_b, done_b;
  logic [15:0] rdata_b;
  logic [1:0]  addr_b;
  logic [7:0]  txd_b;

  reg_dump_unit u_dut_a (
    .i_clock(clk), .i_reset(rst_n), .i_start(start_a), .i_reg_data(rdata_a),
    .i_tx_done(tx_done_a), .o_read_enable(rd_en_a), .o_read_addr(addr_a),
    .o_tx_data(txd_a), .o_tx_start(txs_a), .o_busy(busy_a), .o_done(done_a)
  );

  reg_dump_unit #(.DATA_SIZE(16), .ADDR_SIZE(2), .BANK_DEPTH(4)) u_dut_b (
    .i_clock(clk), .i_reset(rst_n), .i_start(start_b), .i_reg_data(rdata_b),
    .i_tx_done(tx_done_b), .o_read_enable(rd_en_b), .o_read_addr(addr_b),
    .o_tx_data(txd_b), .o_tx_start(txs_b), .o_busy(busy_b), .o_done(done_b)
  );

  // Bank models: data valid the cycle after the read request.
  logic r0_special;
  always @(posedge clk) begin
    if (rd_en_a) rdata_a <= (addr_a == 5'd0 && r0_special) ? 32'h1122_3344 : {4{3'b000, addr_a}};
    if (rd_en_b) rdata_b <= {8'hA1 + {6'b0, addr_b}, 8'hB2 + {6'b0, addr_b}};
  end

  // UART stand-ins: pulse tx_done a programmable number of cycles after each strobe.
  int   dly_a;
  int   cnt_a, cnt_b;
  logic resp_a, resp_b, inj_a;
  always @(posedge clk) begin
    resp_a <= 1'b0;
    if (cnt_a > 0) begin
      cnt_a <= cnt_a - 1;
      if (cnt_a == 1) resp_a <= 1'b1;
    end else if (txs_a) cnt_a <= dly_a;
    resp_b <= 1'b0;
    if (cnt_b > 0) begin
      cnt_b <= cnt_b - 1;
      if (cnt_b == 1) resp_b <= 1'b1;
    end else if (txs_b) cnt_b <= 4;
  end
  assign tx_done_a = resp_a | inj_a;
  assign tx_done_b = resp_b;

  logic [7:0] bytes_a[$];
  logic [7:0] bytes_b[$];
  int         raddr_a[$];
  int         ndone_a, ndone_b, overlap, unstable;
  logic [7:0] last_a;
  always @(negedge clk) begin
    if (txs_a) begin
      bytes_a.push_back(txd_a);
      last_a <= txd_a;
    end
    if (txs_b) bytes_b.push_back(txd_b);
    if (rd_en_a) raddr_a.push_back(int'(addr_a));
    if (done_a) ndone_a <= ndone_a + 1;
    if (done_b) ndone_b <= ndone_b + 1;
    if ((rd_en_a && txs_a) || (rd_en_b && txs_b)) overlap <= overlap + 1;
    if (resp_a && busy_a && !txs_a && txd_a != last_a) unstable <= unstable + 1;
  end

  int n_tot = 0;
  int n_pass = 0;
  task automatic chk(input string tag, input int act, input int exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(input int max, input string tag);
    int i;
    i = 0;
    @(negedge clk);
    while (!done_a && i < max) begin
      @(negedge clk);
      i++;
    end
    if (!done_a) chk({tag, "_timeout"}, 0, 1);
  endtask

  function automatic int exp_a(input int i, input bit sp);
    logic [31:0] w;
    int k;
    k = i / 4;
    w = (k == 0 && sp) ? 32'h1122_3344 : {4{8'(k)}};
    return int'(w[8*(3 - (i % 4)) +: 8]);
  endfunction

  task automatic check_dump_a(input int bb, input int rb, input bit sp, input string tag);
    int bad;
    bad = 0;
    chk({tag, "_nbytes"}, bytes_a.size() - bb, 128);
    for (int i = 0; i < 128 && bb + i < bytes_a.size(); i++)
      if (int'(bytes_a[bb+i]) != exp_a(i, sp)) bad++;
    chk({tag, "_byte_errs"}, bad, 0);
    bad = 0;
    chk({tag, "_nreads"}, raddr_a.size() - rb, 32);
    for (int i = 0; i < 32 && rb + i < raddr_a.size(); i++)
      if (raddr_a[rb+i] != i) bad++;
    chk({tag, "_addr_errs"}, bad, 0);
  endtask

  initial begin
    int bb, rb, nd, bbb, ndb;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; inj_a = 1'b0;
    r0_special = 1'b0; dly_a = 10;
    cyc(3);
    chk("rst_outs_a", int'({rd_en_a, addr_a, txd_a, txs_a, busy_a, done_a}), 0);
    chk("rst_outs_b", int'({rd_en_b, addr_b, txd_b, txs_b, busy_b, done_b}), 0);
    @(negedge clk) rst_n = 1'b1;
    cyc(2);

    // First register special, verify start latency and MSB-first order.
    r0_special = 1'b1; dly_a = 3;
    bb = bytes_a.size(); rb = raddr_a.size(); nd = ndone_a;
    start_a = 1'b1; cyc(1); start_a = 1'b0;
    chk("t033_rd_en", int'(rd_en_a), 1);
    chk("t033_rd_addr", int'(addr_a), 0);
    cyc(1);
    chk("t033_latch_idle", int'({rd_en_a, txs_a}), 0);
    cyc(1);
    chk("t033_send_strobe", int'(txs_a), 1);
    chk("t033_first_byte", int'(txd_a), 'h11);
    for (int i = 0; i < 200 && bytes_a.size() - bb < 4; i++) cyc(1);
    chk("t033_byte0", int'(bytes_a[bb]), 'h11);
    chk("t033_byte1", int'(bytes_a[bb+1]), 'h22);
    chk("t033_byte2", int'(bytes_a[bb+2]), 'h33);
    chk("t033_byte3", int'(bytes_a[bb+3]), 'h44);
    wait_done_a(4000, "t033");
    cyc(2);
    chk("t033_ndone", ndone_a - nd, 1);
    check_dump_a(bb, rb, 1'b1, "t033");

    // Full dump, slow transmitter.
    r0_special = 1'b0; dly_a = 10;
    bb = bytes_a.size(); rb = raddr_a.size(); nd = ndone_a;
    start_a = 1'b1; cyc(1); start_a = 1'b0;
    wait_done_a(4000, "t034");
    @(negedge clk);
    chk("t034_busy_after_done", int'(busy_a), 0);
    cyc(2);
    chk("t034_ndone", ndone_a - nd, 1);
    check_dump_a(bb, rb, 1'b0, "t034");

    // Second start while waiting on register 5.
    bb = bytes_a.size(); rb = raddr_a.size(); nd = ndone_a;
    start_a = 1'b1; cyc(1); start_a = 1'b0;
    for (int i = 0; i < 2000 && bytes_a.size() - bb < 21; i++) cyc(1);
    chk("t035_in_wait", int'({busy_a, txs_a, rd_en_a}), 'b100);
    start_a = 1'b1; cyc(1); start_a = 1'b0;
    wait_done_a(4000, "t035");
    cyc(2);
    chk("t035_ndone", ndone_a - nd, 1);
    check_dump_a(bb, rb, 1'b0, "t035");

    // tx_done during READ, LATCH and SEND must be ignored.
    r0_special = 1'b1;
    bb = bytes_a.size(); rb = raddr_a.size(); nd = ndone_a;
    start_a = 1'b1; cyc(1); start_a = 1'b0;
    inj_a = 1'b1;
    cyc(2);
    chk("t036_send_strobe", int'(txs_a), 1);
    chk("t036_send_byte", int'(txd_a), 'h11);
    cyc(1); inj_a = 1'b0;
    chk("t036_wait_byte", int'(txd_a), 'h11);
    wait_done_a(4000, "t036");
    cyc(2);
    chk("t036_ndone", ndone_a - nd, 1);
    check_dump_a(bb, rb, 1'b1, "t036");
    r0_special = 1'b0;

    // Asynchronous reset mid-dump at address 17.
    dly_a = 2;
    rb = raddr_a.size(); nd = ndone_a;
    start_a = 1'b1; cyc(1); start_a = 1'b0;
    for (int i = 0; i < 2000 && raddr_a.size() - rb < 18; i++) cyc(1);
    chk("t037_at_addr17", int'(addr_a), 17);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk("t037_async_outs", int'({rd_en_a, addr_a, txd_a, txs_a, busy_a, done_a}), 0);
    cyc(3);
    @(negedge clk) rst_n = 1'b1;
    cyc(30);
    chk("t037_no_done", ndone_a - nd, 0);
    bb = bytes_a.size(); rb = raddr_a.size(); nd = ndone_a;
    start_a = 1'b1; cyc(1); start_a = 1'b0;
    chk("t037_restart_rd_en", int'(rd_en_a), 1);
    chk("t037_restart_addr", int'(addr_a), 0);
    wait_done_a(4000, "t037");
    cyc(2);
    chk("t037_ndone", ndone_a - nd, 1);
    check_dump_a(bb, rb, 1'b0, "t037");

    // Held start re-arms a new dump straight after FINISH.
    start_a = 1'b1;
    wait_done_a(4000, "t024");
    @(negedge clk);
    chk("t024_idle_gap", int'(busy_a), 0);
    @(negedge clk);
    chk("t024_rearm", int'({busy_a, rd_en_a, addr_a}), 'b1100000);
    #1 start_a = 1'b0; rst_n = 1'b0;
    cyc(3);
    @(negedge clk) rst_n = 1'b1;
    cyc(20);

    // Narrow instance: 2 bytes per register, 4 registers.
    bbb = bytes_b.size(); ndb = ndone_b;
    start_b = 1'b1; cyc(1); start_b = 1'b0;
    for (int i = 0; i < 500 && !done_b; i++) @(negedge clk);
    if (!done_b) chk("t038_timeout", 0, 1);
    cyc(2);
    chk("t038_ndone", ndone_b - ndb, 1);
    chk("t038_nbytes", bytes_b.size() - bbb, 8);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 8 && bbb + i < bytes_b.size(); i++)
        if (int'(bytes_b[bbb+i]) != ((i % 2 == 0) ? 'hA1 + i/2 : 'hB2 + i/2)) bad++;
      chk("t038_byte_errs", bad, 0);
    end
    chk("t038_b_reg1_hi", int'(bytes_b[bbb+2]), 'hA2);

    chk("read_tx_overlap", overlap, 0);
    chk("tx_data_stable", unstable, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
